// File: rtl/ungapped_extend_if.sv
// Handshake/data bundle between the hit detector, the host and ungapped_extend.
// The master side drives query, database window and seed hits; the slave reports results.
interface ungapped_extend_if #(
    parameter int SCORE_W = 12
);
    logic [511:0]              query;
    logic                      queryValid;
    logic [511:0]              dataBase;
    logic                      startExpand;
    logic [8:0]                locationQ;
    logic [8:0]                locationD;
    logic                      busy;
    logic                      stop;
    logic                      done;
    logic                      hitValid;
    logic signed [SCORE_W-1:0] score;
    logic [7:0]                qStart;
    logic [7:0]                qEnd;
    logic [7:0]                dStart;
    logic [7:0]                dEnd;
    logic [31:0]               extCount;
    logic [31:0]               passCount;

    modport master (
        output query, queryValid, dataBase, startExpand, locationQ, locationD,
        input  busy, stop, done, hitValid, score, qStart, qEnd, dStart, dEnd,
               extCount, passCount
    );

    modport slave (
        input  query, queryValid, dataBase, startExpand, locationQ, locationD,
        output busy, stop, done, hitValid, score, qStart, qEnd, dStart, dEnd,
               extCount, passCount
    );
endinterface

// File: rtl/ungapped_extend.sv
// Bidirectional ungapped X-drop extension of a seed hit, one nucleotide per side per cycle.
// Optional statistics counters are built when UNGAPPED_STATS_EN is defined.
module ungapped_extend #(
    parameter int SEED_LEN  = 11,
    parameter int MATCH     = 1,
    parameter int MISMATCH  = 3,
    parameter int XDROP     = 10,
    parameter int THRESHOLD = 20,
    parameter int SCORE_W   = 12
) (
    input  logic               clk,
    input  logic               rst,
    ungapped_extend_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, INIT, EXTEND, REPORT} state_t;

    localparam logic signed [SCORE_W-1:0] MATCH_S = SCORE_W'(MATCH);
    localparam logic signed [SCORE_W-1:0] MIS_S   = SCORE_W'(MISMATCH);
    localparam logic signed [SCORE_W-1:0] XDROP_S = SCORE_W'(XDROP);
    localparam logic signed [SCORE_W-1:0] SEED_S  = SCORE_W'(SEED_LEN * MATCH);
    localparam logic signed [SCORE_W-1:0] THR_S   = SCORE_W'(THRESHOLD);

    state_t stateReg, stateNext;
    logic [511:0] queryReg, dbReg;
    logic [7:0]   qnReg, dnReg;
    logic [7:0]   lqReg, ldReg, rqReg, rdReg;
    logic         leftActReg, rightActReg, invalidReg;
    logic signed [SCORE_W-1:0] leftScoreReg, leftBestReg, rightScoreReg, rightBestReg;
    logic [7:0]   qStartBestReg, qEndBestReg, dStartBestReg, dEndBestReg;
    logic signed [SCORE_W-1:0] scoreReg;
    logic         hitValidReg;
    logic [7:0]   qStartReg, qEndReg, dStartReg, dEndReg;

    // Seed offsets are always even; the LSBs carry no information.
    logic unusedLsbs;
    assign unusedLsbs = bus.locationQ[0] ^ bus.locationD[0];

    logic [8:0] qnExt, dnExt;
    logic       seedBad;
    logic       leftMatch, rightMatch, leftImprove, rightImprove, leftStop, rightStop;
    logic signed [SCORE_W-1:0] leftScoreNew, rightScoreNew, leftBestNew, rightBestNew;
    logic signed [SCORE_W-1:0] leftDrop, rightDrop, totalScore;

    always_comb begin
        qnExt         = {1'b0, qnReg} + 9'(SEED_LEN);
        dnExt         = {1'b0, dnReg} + 9'(SEED_LEN);
        seedBad       = (qnExt > 9'd256) || (dnExt > 9'd256);
        leftMatch     = queryReg[{lqReg, 1'b0} +: 2] == dbReg[{ldReg, 1'b0} +: 2];
        rightMatch    = queryReg[{rqReg, 1'b0} +: 2] == dbReg[{rdReg, 1'b0} +: 2];
        leftScoreNew  = leftMatch  ? leftScoreReg  + MATCH_S : leftScoreReg  - MIS_S;
        rightScoreNew = rightMatch ? rightScoreReg + MATCH_S : rightScoreReg - MIS_S;
        leftImprove   = leftScoreNew  > leftBestReg;
        rightImprove  = rightScoreNew > rightBestReg;
        leftBestNew   = leftImprove  ? leftScoreNew  : leftBestReg;
        rightBestNew  = rightImprove ? rightScoreNew : rightBestReg;
        leftDrop      = leftBestNew  - leftScoreNew;
        rightDrop     = rightBestNew - rightScoreNew;
        leftStop      = (leftDrop  > XDROP_S) || (lqReg == 8'd0)   || (ldReg == 8'd0);
        rightStop     = (rightDrop > XDROP_S) || (rqReg == 8'd255) || (rdReg == 8'd255);
        totalScore    = SEED_S + leftBestReg + rightBestReg;
    end

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE:    if (bus.startExpand) stateNext = INIT;
            INIT:    stateNext = EXTEND;
            EXTEND:  if (!leftActReg && !rightActReg) stateNext = REPORT;
            REPORT:  stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign bus.busy     = (stateReg != IDLE);
    assign bus.done     = (stateReg == REPORT);
    assign bus.stop     = (stateReg == REPORT);
    assign bus.score    = scoreReg;
    assign bus.hitValid = hitValidReg;
    assign bus.qStart   = qStartReg;
    assign bus.qEnd     = qEndReg;
    assign bus.dStart   = dStartReg;
    assign bus.dEnd     = dEndReg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateReg      <= IDLE;
            queryReg      <= '0;
            dbReg         <= '0;
            qnReg         <= '0;
            dnReg         <= '0;
            lqReg         <= '0;
            ldReg         <= '0;
            rqReg         <= '0;
            rdReg         <= '0;
            leftActReg    <= 1'b0;
            rightActReg   <= 1'b0;
            invalidReg    <= 1'b0;
            leftScoreReg  <= '0;
            leftBestReg   <= '0;
            rightScoreReg <= '0;
            rightBestReg  <= '0;
            qStartBestReg <= '0;
            qEndBestReg   <= '0;
            dStartBestReg <= '0;
            dEndBestReg   <= '0;
            scoreReg      <= '0;
            hitValidReg   <= 1'b0;
            qStartReg     <= '0;
            qEndReg       <= '0;
            dStartReg     <= '0;
            dEndReg       <= '0;
        end else begin
            stateReg <= stateNext;
            if (bus.queryValid) queryReg <= bus.query;
            case (stateReg)
                IDLE: if (bus.startExpand) begin
                    dbReg <= bus.dataBase;
                    qnReg <= bus.locationQ[8:1];
                    dnReg <= bus.locationD[8:1];
                end
                INIT: begin
                    lqReg         <= qnReg - 8'd1;
                    ldReg         <= dnReg - 8'd1;
                    rqReg         <= qnExt[7:0];
                    rdReg         <= dnExt[7:0];
                    leftScoreReg  <= '0;
                    leftBestReg   <= '0;
                    rightScoreReg <= '0;
                    rightBestReg  <= '0;
                    invalidReg    <= seedBad;
                    leftActReg    <= !seedBad && (qnReg != 8'd0) && (dnReg != 8'd0);
                    rightActReg   <= !seedBad && (qnExt <= 9'd255) && (dnExt <= 9'd255);
                    qStartBestReg <= qnReg;
                    dStartBestReg <= dnReg;
                    // An invalid seed reports zero-width extents at the seed start.
                    qEndBestReg   <= seedBad ? qnReg : qnReg + 8'(SEED_LEN - 1);
                    dEndBestReg   <= seedBad ? dnReg : dnReg + 8'(SEED_LEN - 1);
                end
                EXTEND: begin
                    if (leftActReg) begin
                        leftScoreReg <= leftScoreNew;
                        leftBestReg  <= leftBestNew;
                        if (leftImprove) begin
                            qStartBestReg <= lqReg;
                            dStartBestReg <= ldReg;
                        end
                        if (leftStop) leftActReg <= 1'b0;
                        else begin
                            lqReg <= lqReg - 8'd1;
                            ldReg <= ldReg - 8'd1;
                        end
                    end
                    if (rightActReg) begin
                        rightScoreReg <= rightScoreNew;
                        rightBestReg  <= rightBestNew;
                        if (rightImprove) begin
                            qEndBestReg <= rqReg;
                            dEndBestReg <= rdReg;
                        end
                        if (rightStop) rightActReg <= 1'b0;
                        else begin
                            rqReg <= rqReg + 8'd1;
                            rdReg <= rdReg + 8'd1;
                        end
                    end
                    if (!leftActReg && !rightActReg) begin
                        scoreReg    <= invalidReg ? '0 : totalScore;
                        hitValidReg <= !invalidReg && (totalScore >= THR_S);
                        qStartReg   <= qStartBestReg;
                        qEndReg     <= qEndBestReg;
                        dStartReg   <= dStartBestReg;
                        dEndReg     <= dEndBestReg;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef UNGAPPED_STATS_EN
    logic [31:0] extCountReg, passCountReg;
    always_ff @(posedge clk) begin
        if (!rst) begin
            extCountReg  <= '0;
            passCountReg <= '0;
        end else if (stateReg == REPORT) begin
            extCountReg <= extCountReg + 32'd1;
            if (hitValidReg) passCountReg <= passCountReg + 32'd1;
        end
    end
    assign bus.extCount  = extCountReg;
    assign bus.passCount = passCountReg;
`else
    assign bus.extCount  = '0;
    assign bus.passCount = '0;
`endif
endmodule

// File: doc/ungapped_extend.md
Name: ungapped_extend

Overview:
- Stage directly downstream of the seed hit detector.
- On each seed-hit pulse, latches the hit position pair (query offset, database offset) and the current 512-bit database window.
- Performs bidirectional ungapped X-drop extension, one nucleotide per side per cycle, and reports score, extents and pass/fail.
- Pulses `stop` back to the hit detector when finished, so it can re-arm and reposition its shift register.

Parameters:
- SEED_LEN, 11: seed length in nucleotides (22 bits).
- MATCH, 1: score added per matching nucleotide.
- MISMATCH, 3: penalty subtracted per mismatching nucleotide.
- XDROP, 10: a side terminates when (sideBest - sideScore) > XDROP.
- THRESHOLD, 20: `hitValid` is set when score >= THRESHOLD.
- SCORE_W, 12: signed score width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- query  in  512  256 nucleotides, 2 bits each; nucleotide n = bits [2n+1:2n].
- queryValid  in  1  latch `query` into the internal query register.
- dataBase  in  512  current database window, same packing as `query`.
- startExpand  in  1  seed hit pulse from the hit detector.
- locationQ  in  9  query bit offset of the seed (even); qn = locationQ/2.
- locationD  in  9  database bit offset of the seed (even, from the detector's shift count); dn = locationD/2.
- busy  out  1  high in EXTEND and REPORT.
- stop  out  1  one-cycle pulse in REPORT; drives the hit detector's stop input.
- done  out  1  one-cycle pulse in REPORT.
- hitValid  out  1  valid with `done`; score >= THRESHOLD.
- score  out  SCORE_W  total ungapped score, held until the next start.
- qStart, qEnd  out  8  inclusive query nucleotide extent.
- dStart, dEnd  out  8  inclusive database nucleotide extent.
- extCount, passCount  out  32  statistics counters (see Optional Feature).

Behaviour:
- Reset (rst=0 at clk edge):
  - State returns to IDLE; every output goes to 0.
  - The query register is cleared.
  - Applies mid-extension as well; no report or stop pulse is issued for the aborted extension.
- `queryValid` latches `query` in any state. Software must not assert it while `busy` is high.
- IDLE:
  - `startExpand` = 1 latches `dataBase`, qn and dn, then moves to EXTEND.
  - Validity check: if qn+SEED_LEN > 256 or dn+SEED_LEN > 256, the seed is invalid. Go straight to REPORT with score = 0, hitValid = 0, and all extents = qn/dn.
- Initialisation:
  - Left pointers: qn-1, dn-1.
  - Right pointers: qn+SEED_LEN, dn+SEED_LEN.
  - sideScore = sideBest = 0 on each side; best extents = seed edges.
  - A side starts inactive if its pointer is out of range (left pointer < 0, right pointer > 255).
- EXTEND, each cycle, for each active side:
  - Compare one nucleotide pair; add MATCH or subtract MISMATCH.
  - If the new sideScore > sideBest (strictly greater), update sideBest and record the pointers as the extent. Ties keep the shorter extent.
  - Deactivate the side if (sideBest - sideScore) > XDROP, or if this pointer was the last index (0 on the left, 255 on the right, in either sequence).
  - Otherwise step the pointer by one.
  - When both sides are inactive, move to REPORT.
  - Arithmetic is signed SCORE_W with no saturation; maximum magnitude is 256*3, which fits in 12 bits.
- REPORT (one cycle):
  - score = SEED_LEN*MATCH + leftBest + rightBest.
  - hitValid = (score >= THRESHOLD).
  - `done` and `stop` are high; then return to IDLE.
- Latency: `done` is high exactly 2 + max(L,R) cycles after the edge that sampled `startExpand`, where L and R are the nucleotides examined on each side. An invalid seed, or L = R = 0, gives 2 cycles.
- `startExpand` while busy is ignored and not queued. `startExpand` in the REPORT cycle is also ignored.

Optional Feature:
- Macro: UNGAPPED_STATS_EN.
- Defined: `extCount` increments on every REPORT; `passCount` increments on every REPORT with hitValid = 1. Both wrap at 2^32 and are cleared by reset.
- Undefined: no counter logic; `extCount` and `passCount` are tied to 0.

Test Plan:
- Full match, query == dataBase, locationQ = locationD = 200 (qn = 100):
  - score = 256, qStart = 0, qEnd = 255, hitValid = 1.
  - `done` exactly 147 cycles after start; `stop` pulses together with `done`.
- X-drop, query == dataBase except database nucleotides 115..125 complemented, seed at 100:
  - Right side stops after examining 111..118; qEnd = 114.
  - score = 115; `done` after 102 cycles.
- Boundaries:
  - locationQ = 490 (qn = 245): valid, right side examines nothing, qEnd = 255.
  - locationQ = 492: invalid; `done` after 2 cycles with score = 0, hitValid = 0.
- Below threshold, random query and database, seed at 50:
  - score < 20, hitValid = 0; `done` and `stop` still pulse.
  - With UNGAPPED_STATS_EN defined: extCount = 1, passCount = 0.
- Busy and reset:
  - Second `startExpand` pulse mid-EXTEND is ignored, giving exactly one `done`.
  - rst = 0 mid-EXTEND: next cycle busy = 0 and all outputs are 0, with no `done` or `stop` pulse.
